// File: rtl/rrf_alloc_ctrl_pkg.sv
// rrf_alloc_ctrl_pkg: RRF pool geometry and dispatch width shared by the allocator.
package rrf_alloc_ctrl_pkg;
  localparam int RRF_NUM = 64;
  localparam int RRF_SEL = 6;
  localparam int DISP_WIDTH = 2;
endpackage

// File: rtl/rrf_alloc_ctrl.sv
// rrf_alloc_ctrl: in-order RRF tag allocator/free-list with commit retirement and flush rollback.
module rrf_alloc_ctrl #(
  parameter int RRF_NUM = rrf_alloc_ctrl_pkg::RRF_NUM,
  parameter int RRF_SEL = rrf_alloc_ctrl_pkg::RRF_SEL
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         req_num_i,
  output logic               alloc_en0_o,
  output logic [RRF_SEL-1:0] alloc_tag0_o,
  output logic               alloc_en1_o,
  output logic [RRF_SEL-1:0] alloc_tag1_o,
  output logic               stall_o,
  input  logic [1:0]         commit_num_i,
  output logic [RRF_SEL-1:0] completed_dst_rrftag0_o,
  output logic [RRF_SEL-1:0] completed_dst_rrftag1_o,
  input  logic               flush_i,
  input  logic [RRF_SEL-1:0] flush_ptr_i,
  output logic [RRF_SEL:0]   free_num_o
);
  localparam logic [RRF_SEL:0] FULL = (RRF_SEL+1)'(RRF_NUM);
  localparam logic [1:0] DISP = 2'(rrf_alloc_ctrl_pkg::DISP_WIDTH);
  logic [RRF_SEL-1:0] alloc_ptr, com_ptr, alloc_next, com_next;
  logic [RRF_SEL:0] free_num, free_next, used;
  logic [1:0] r, gnt_n, eff_c;
  logic grant;
  function automatic logic [RRF_SEL-1:0] ptr_add(input logic [RRF_SEL-1:0] ptr, input logic [1:0] n);
    return ptr + RRF_SEL'(n);
  endfunction
  always_comb begin
    r = req_num_i > DISP ? DISP : req_num_i;
    grant = !flush_i && !reset_i && ({{(RRF_SEL-1){1'b0}}, r} <= free_num);
    gnt_n = grant ? r : 2'd0;
    used = FULL - free_num;
    eff_c = {{(RRF_SEL-1){1'b0}}, commit_num_i} > used ? used[1:0] : commit_num_i;
    com_next = ptr_add(com_ptr, eff_c);
    // A flush to the current alloc_ptr is a no-op; otherwise occupancy is rebuilt from the pointers
    alloc_next = flush_i ? flush_ptr_i : ptr_add(alloc_ptr, gnt_n);
    free_next = !flush_i ? free_num - (RRF_SEL+1)'(gnt_n) + (RRF_SEL+1)'(eff_c)
              : flush_ptr_i == alloc_ptr ? free_num + (RRF_SEL+1)'(eff_c)
              : FULL - {1'b0, RRF_SEL'(flush_ptr_i - com_next)};
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      alloc_ptr <= '0;
      com_ptr <= '0;
      free_num <= FULL;
    end else begin
      alloc_ptr <= alloc_next;
      com_ptr <= com_next;
      free_num <= free_next;
    end
  end
  assign alloc_en0_o = grant && r != 2'd0;
  assign alloc_en1_o = grant && r == 2'd2;
  assign stall_o = !reset_i && r != 2'd0 && !grant;
  assign alloc_tag0_o = alloc_ptr;
  assign alloc_tag1_o = ptr_add(alloc_ptr, 2'd1);
  assign completed_dst_rrftag0_o = com_ptr;
  assign completed_dst_rrftag1_o = ptr_add(com_ptr, 2'd1);
  assign free_num_o = free_num;
endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// tb_rrf_alloc_ctrl: directed vector table for the RRF allocator, outputs checked before each edge.
module tb_rrf_alloc_ctrl;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic [1:0] req_num_i = 2'd0, commit_num_i = 2'd0;
  logic flush_i = 1'b0;
  logic [5:0] flush_ptr_i = 6'd0;
  logic alloc_en0_o, alloc_en1_o, stall_o;
  logic [5:0] alloc_tag0_o, alloc_tag1_o, completed_dst_rrftag0_o, completed_dst_rrftag1_o;
  logic [6:0] free_num_o;
  int tests = 0, fails = 0;
  typedef struct {
    logic rst; logic [1:0] req; logic [1:0] com; logic fl; logic [5:0] fp;
    logic en0; logic en1; logic stall; logic [5:0] tag0; logic [5:0] ctag0; logic [6:0] free;
  } vec_t;
  vec_t vq[$];

  rrf_alloc_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_num_i(req_num_i),
    .alloc_en0_o(alloc_en0_o), .alloc_tag0_o(alloc_tag0_o),
    .alloc_en1_o(alloc_en1_o), .alloc_tag1_o(alloc_tag1_o),
    .stall_o(stall_o), .commit_num_i(commit_num_i),
    .completed_dst_rrftag0_o(completed_dst_rrftag0_o),
    .completed_dst_rrftag1_o(completed_dst_rrftag1_o),
    .flush_i(flush_i), .flush_ptr_i(flush_ptr_i), .free_num_o(free_num_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(logic rst, logic [1:0] req, logic [1:0] com, logic fl, logic [5:0] fp,
                              logic en0, logic en1, logic stall, logic [5:0] tag0, logic [5:0] ctag0, logic [6:0] free);
    vec_t v;
    v.rst = rst; v.req = req; v.com = com; v.fl = fl; v.fp = fp;
    v.en0 = en0; v.en1 = en1; v.stall = stall; v.tag0 = tag0; v.ctag0 = ctag0; v.free = free;
    return v;
  endfunction

  initial begin
    logic [5:0] t1, c1;
    vq.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 64));
    for (int i = 0; i < 32; i++) vq.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 6'(2*i), 0, 7'(64-2*i)));
    vq.push_back(mk(0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // freed entries are not allocatable in the cycle they are committed
    vq.push_back(mk(0, 2, 2, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 0, 2, 2));
    for (int k = 0; k < 31; k++) vq.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 2, 6'(2+2*k), 7'(2*k)));
    for (int k = 0; k < 30; k++) vq.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 6'(2+2*k), 0, 7'(62-2*k)));
    vq.push_back(mk(0, 1, 2, 0, 0, 1, 0, 0, 62, 0, 2));
    vq.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 63, 2, 3));
    vq.push_back(mk(0, 2, 0, 0, 0, 0, 0, 1, 1, 2, 1));
    vq.push_back(mk(0, 3, 0, 0, 0, 0, 0, 1, 1, 2, 1));
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 2, 1));
    vq.push_back(mk(0, 2, 0, 1, 2, 0, 0, 1, 2, 2, 0));
    vq.push_back(mk(0, 0, 1, 1, 2, 0, 0, 0, 2, 2, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 3, 1));
    for (int i = 0; i < 10; i++) vq.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 6'(2*i), 0, 7'(64-2*i)));
    vq.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 20, 0, 44));
    vq.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 20, 2, 46));
    vq.push_back(mk(0, 2, 1, 1, 10, 0, 0, 1, 20, 4, 48));
    vq.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0, 10, 5, 59));
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 5, 5, 64));
    vq.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 6, 5, 63));
    vq.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 6, 6, 64));
    vq.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 6, 6, 64));
    vq.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 8, 6, 62));
    vq.push_back(mk(1, 2, 1, 1, 7, 0, 0, 0, 10, 6, 60));
    vq.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 0, 0, 64));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 62));
    @(posedge clk_i);
    foreach (vq[n]) begin
      @(negedge clk_i);
      reset_i = vq[n].rst; req_num_i = vq[n].req; commit_num_i = vq[n].com;
      flush_i = vq[n].fl; flush_ptr_i = vq[n].fp;
      #1;
      t1 = vq[n].tag0 + 6'd1;
      c1 = vq[n].ctag0 + 6'd1;
      tests++;
      if ({alloc_en0_o, alloc_en1_o, stall_o, alloc_tag0_o, alloc_tag1_o, completed_dst_rrftag0_o, completed_dst_rrftag1_o, free_num_o}
          !== {vq[n].en0, vq[n].en1, vq[n].stall, vq[n].tag0, t1, vq[n].ctag0, c1, vq[n].free}) begin
        fails++;
        $display("FAIL vec%0d: got en=%b%b stall=%b tag=%0d/%0d ctag=%0d/%0d free=%0d, want en=%b%b stall=%b tag=%0d/%0d ctag=%0d/%0d free=%0d",
                 n, alloc_en0_o, alloc_en1_o, stall_o, alloc_tag0_o, alloc_tag1_o, completed_dst_rrftag0_o,
                 completed_dst_rrftag1_o, free_num_o, vq[n].en0, vq[n].en1, vq[n].stall, vq[n].tag0, t1,
                 vq[n].ctag0, c1, vq[n].free);
      end
      tests++;
      if (6'(alloc_tag0_o - completed_dst_rrftag0_o) !== 6'(7'd64 - free_num_o)) begin
        fails++;
        $display("FAIL invariant vec%0d: alloc-com=%0d, want 64-free=%0d", n,
                 6'(alloc_tag0_o - completed_dst_rrftag0_o), 6'(7'd64 - free_num_o));
      end
    end
    @(negedge clk_i);
    reset_i = 1'b0; req_num_i = 2'd0; commit_num_i = 2'd0; flush_i = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rrf_alloc_ctrl.md
Name: rrf_alloc_ctrl

Overview:
- Allocation and free-list controller for the rename register file (RRF).
- Hands out RRF tags in order from a circular pool to the dispatch stage, up to 2 per cycle.
- Drives the RRF allocate port, which clears the entry's valid bit.
- Retires tags in order on commit and drives the commit-side RRF read tags that feed the ARF copy.
- Rolls back the allocation pointer on a branch-mispredict flush.

Parameters:
- RRF_NUM, 64, number of RRF entries; must be a power of two.
- RRF_SEL, 6, tag width; equals log2(RRF_NUM).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, synchronous, active-high
- req_num_i  in  2  number of tags dispatch requests this cycle (0..2); value 3 is treated as 2
- alloc_en0_o  out  1  lane-0 tag granted; drives the RRF allocate_rrf_en_i port
- alloc_tag0_o  out  RRF_SEL  lane-0 tag; drives the RRF allocate_rrftag_i port
- alloc_en1_o  out  1  lane-1 tag granted
- alloc_tag1_o  out  RRF_SEL  lane-1 tag
- stall_o  out  1  request cannot be granted this cycle
- commit_num_i  in  2  tags retired by the commit stage this cycle (0..2)
- completed_dst_rrftag0_o  out  RRF_SEL  oldest live tag; drives the RRF completed_dst_rrftag_i port
- completed_dst_rrftag1_o  out  RRF_SEL  second-oldest live tag
- flush_i  in  1  mispredict recovery
- flush_ptr_i  in  RRF_SEL  first tag to discard; every tag from here up to alloc_ptr-1 is freed
- free_num_o  out  RRF_SEL+1  current free-entry count

Behaviour:
- State registers:
  - alloc_ptr (RRF_SEL)
  - com_ptr (RRF_SEL)
  - free_num (RRF_SEL+1)
- Reset: alloc_ptr=0, com_ptr=0, free_num=RRF_NUM.
  - Reset outputs: alloc_en0/1=0, stall_o=0, alloc_tag0=0, alloc_tag1=1, completed tags 0/1, free_num_o=RRF_NUM.
  - Reset takes priority over flush, request and commit in the same cycle.
- Pointer arithmetic is modulo RRF_NUM; wrap is implicit via the power-of-two truncation.
- Tag outputs (combinational):
  - alloc_tag0=alloc_ptr, alloc_tag1=alloc_ptr+1.
  - completed_dst_rrftag0=com_ptr, completed_dst_rrftag1=com_ptr+1.
- Grant (combinational, zero latency), with r=min(req_num_i,2):
  - grant = !flush_i && !reset_i && (r <= free_num).
  - alloc_en0 = grant && r>=1; alloc_en1 = grant && r==2.
  - stall_o = !reset_i && r!=0 && !grant.
  - A grant is all-or-nothing: never a partial grant of 1 when 2 are requested.
- Commit:
  - eff_c = min(commit_num_i, RRF_NUM-free_num); any excess is silently clipped.
  - Commit is applied even during flush.
- Next state, normal cycle:
  - alloc_ptr += granted count; com_ptr += eff_c.
  - free_num = free_num - granted + eff_c.
  - Entries freed this cycle are not allocatable until the next cycle: the grant check uses the registered free_num.
- Next state, flush cycle:
  - com_ptr advances by eff_c first, giving com_next.
  - If flush_ptr_i == alloc_ptr: no-op on alloc_ptr; free_num = free_num + eff_c. This resolves the full-pool ambiguity.
  - Else: alloc_ptr = flush_ptr_i; occ = (flush_ptr_i - com_next) mod RRF_NUM; free_num = RRF_NUM - occ. Here occ=0 means all in-flight tags are discarded.
  - flush_ptr_i must lie within [com_next, alloc_ptr]; behaviour outside that range is undefined.
- Invariant, checked by a bench assertion: (alloc_ptr - com_ptr) mod RRF_NUM == RRF_NUM - free_num, except when free_num==0, where alloc_ptr==com_ptr.
- Boundaries:
  - free_num=1 with r=2 → stall, no lane granted.
  - free_num=0 with r=1 → stall.
  - Empty pool with commit_num_i=2 → no state change.

Decomposition:
- Shared package (Consts.vh) holds RRF_NUM, RRF_SEL and a new DISP_WIDTH=2 constant.
- Single flat module; no sub-module is warranted.
- An internal function ptr_add(ptr, n) is shared by all pointer updates.

Test Plan:
- Reset, then r=2 every cycle with no commits → grants tags (0,1),(2,3),…,(62,63); 33rd request stalls; free_num_o=0.
- Full pool, commit_num=2 and r=2 in the same cycle → stall this cycle; next cycle grants tags (0,1), com_ptr=2, free_num=0.
- alloc_ptr=63, free_num≥2, r=2 → tags 63 and 0 granted; alloc_ptr=1.
- alloc_ptr=20, com_ptr=4, flush_ptr=10, commit_num=1 → alloc_ptr=10, com_ptr=5, free_num=59, no grant that cycle.
- Full pool (alloc_ptr=com_ptr=8, free_num=0), flush_ptr=8 → no-op: free_num stays 0; with commit_num=1 → free_num=1.
- free_num=63 (one live tag), commit_num=2 → eff_c=1, free_num=64; reset asserted mid-fill → all registers return to their reset values in the next cycle.
